// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide controller for the EX stage.
//
// Owns the HI/LO registers and sequences mult/multu/div/divu/mfhi/mflo/
// mthi/mtlo. Arithmetic results are computed when the operation is accepted,
// held in pending registers, and committed to HI/LO after a fixed,
// parameterised latency, during which busy is high.
//
// Build option:
//   MDU_ZERO_LATENCY_EN  defined   -> results written at the accept edge,
//                                     busy tied low, no counter
//                        undefined -> MULT_CYCLES / DIV_CYCLES latency
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..255)
//   DIV_CYCLES   busy cycles for div/divu   (1..255)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   EX holds a valid MDU instruction
//   kill   in   flush this cycle, suppresses start
//   MDUOp  in   [3:0] 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//               7 mthi,8 mtlo, 9..15 none
//   A, B   in   [31:0] rs / rt operands
//   busy   out  operation in progress
//   HI, LO out  [31:0] architectural HI/LO
//   rdata  out  [31:0] HI for mfhi, LO for mflo, else 0 (combinational)
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        kill,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] rdata
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic signed [31:0] INT_MIN = 32'sh8000_0000;

   // Returns {hi, lo} of the signed 64-bit product.
   function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      logic signed [63:0] ax;
      logic signed [63:0] bx;
      logic signed [63:0] p;
      ax = a;
      bx = b;
      p  = ax * bx;
      return p;
   endfunction

   function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                                input logic [31:0] b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Returns {remainder, quotient}. INT_MIN / -1 overflows a 32-bit quotient,
   // so it is pinned to the architectural answer instead of relying on the
   // wrap of the native operator.
   function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      logic signed [31:0] q;
      logic signed [31:0] r;
      if (b == 32'sd0) begin
         q = 32'sd0;
         r = 32'sd0;
      end else if (a == INT_MIN && b == -32'sd1) begin
         q = INT_MIN;
         r = 32'sd0;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                                input logic [31:0] b);
      if (b == 32'd0)
         return 64'd0;
      return {a % b, a / b};
   endfunction

   logic        go;
   logic        is_mul;
   logic        is_div;
   logic        div_zero;
   logic        arith_go;
   logic [63:0] res;

   assign go       = start & ~kill & ~busy;
   assign is_mul   = (MDUOp == OP_MULT) | (MDUOp == OP_MULTU);
   assign is_div   = (MDUOp == OP_DIV)  | (MDUOp == OP_DIVU);
   assign div_zero = is_div & (B == 32'd0);
   // Divide by zero is accepted but produces no busy period and no write.
   assign arith_go = go & (is_mul | (is_div & ~div_zero));

   always_comb begin
      res = 64'd0;
      case (MDUOp)
         OP_MULT:  res = mul_signed($signed(A), $signed(B));
         OP_MULTU: res = mul_unsigned(A, B);
         OP_DIV:   res = div_signed($signed(A), $signed(B));
         OP_DIVU:  res = div_unsigned(A, B);
         default:  res = 64'd0;
      endcase
   end

   always_comb begin
      rdata = 32'd0;
      if (MDUOp == OP_MFHI)
         rdata = HI;
      else if (MDUOp == OP_MFLO)
         rdata = LO;
   end

`ifdef MDU_ZERO_LATENCY_EN

   assign busy = 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else if (arith_go) begin
         HI <= res[63:32];
         LO <= res[31:0];
      end else if (go && MDUOp == OP_MTHI) begin
         HI <= A;
      end else if (go && MDUOp == OP_MTLO) begin
         LO <= A;
      end
   end

`else

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   state_t      state_nx;
   logic [7:0]  count;
   logic [7:0]  count_nx;
   logic        pend_ld;
   logic        hilo_ld;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;

   assign busy = (state == RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= 8'd0;
      end else begin
         state <= state_nx;
         count <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      count_nx = count;
      pend_ld  = 1'b0;
      hilo_ld  = 1'b0;
      case (state)
         IDLE: begin
            if (arith_go) begin
               state_nx = RUN;
               count_nx = is_mul ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
               pend_ld  = 1'b1;
            end
         end
         RUN: begin
            count_nx = count - 8'd1;
            // The 1 -> 0 edge commits the pending result.
            if (count == 8'd1) begin
               state_nx = IDLE;
               hilo_ld  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            count_nx = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else if (pend_ld) begin
         pend_hi <= res[63:32];
         pend_lo <= res[31:0];
      end
   end

   // go is never high during RUN, so completion and mthi/mtlo cannot collide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else if (hilo_ld) begin
         HI <= pend_hi;
         LO <= pend_lo;
      end else if (go && MDUOp == OP_MTHI) begin
         HI <= A;
      end else if (go && MDUOp == OP_MTLO) begin
         LO <= A;
      end
   end

`endif

endmodule
